// File: rtl/netlist_bist_engine_if.sv
// Host/netlist-facing signal bundle of the BIST engine.
// Handshake: start_i is a one-cycle request with no ready; the engine takes it
// only when done_o is high or the engine is idle (busy_o low), and ignores it
// while busy_o is high. abort_i is a level that wins over start_i. pass_o is
// qualified by done_o. rsp_i is sampled only in the cycles the engine's internal
// valid-delay line marks as carrying a response. No backpressure exists on any path.
interface netlist_bist_engine_if #(
    parameter int N_IN  = 14,
    parameter int N_OUT = 8
);
    logic              start_i;
    logic              abort_i;
    logic [N_IN-1:0]   seed_i;
    logic [N_OUT-1:0]  golden_i;
    logic [N_IN-1:0]   pat_o;
    logic [N_OUT-1:0]  rsp_i;
    logic              busy_o;
    logic              done_o;
    logic              pass_o;
    logic [N_OUT-1:0]  sig_o;
    logic [16:0]       cnt_o;
    logic [2:0]        dbg_state;

    // Host / netlist side.
    modport master (
        output start_i, abort_i, seed_i, golden_i, rsp_i,
        input  pat_o, busy_o, done_o, pass_o, sig_o, cnt_o, dbg_state
    );

    // Engine side.
    modport slave (
        input  start_i, abort_i, seed_i, golden_i, rsp_i,
        output pat_o, busy_o, done_o, pass_o, sig_o, cnt_o, dbg_state
    );
endinterface

// File: rtl/netlist_bist_engine.sv
// BIST engine for combinational gate netlists: a Galois LFSR issues NUM_PAT
// patterns, a MISR compacts the (optionally LAT-stage pipelined) responses and
// the final signature is compared with a golden value latched at start.
// N_IN/N_OUT must match the parameters of the connected interface instance.
module netlist_bist_engine #(
    parameter int               N_IN     = 14,
    parameter int               N_OUT    = 8,
    parameter logic [N_IN-1:0]  TAPS_IN  = 14'h2B01,
    parameter logic [N_OUT-1:0] TAPS_OUT = 8'h1D,
    parameter int               NUM_PAT  = 1024,
    parameter int               LAT      = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    netlist_bist_engine_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEED  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int          VW        = LAT + 1;
    localparam logic [16:0] NUM_PAT_C = 17'(NUM_PAT);
    localparam logic [16:0] LAST_CNT  = NUM_PAT_C - 17'd1;

    logic [2:0]       state;
    logic [N_IN-1:0]  lfsr;
    logic [N_IN-1:0]  lfsr_next;
    logic [N_IN-1:0]  pat;
    logic [N_OUT-1:0] misr;
    logic [N_OUT-1:0] misr_next;
    logic [N_OUT-1:0] golden;
    logic [16:0]      cnt;
    logic [VW-1:0]    vpipe;
    logic             pass;
    logic             issue;
    logic             capture;

    // Next-state values of the pattern generator and the signature register.
    always_comb begin
        lfsr_next = {lfsr[N_IN-2:0], 1'b0} ^ (lfsr[N_IN-1] ? TAPS_IN : '0);
        misr_next = {misr[N_OUT-2:0], 1'b0} ^ (misr[N_OUT-1] ? TAPS_OUT : '0) ^ bus.rsp_i;
    end

    // A pattern leaves on pat_o this edge; its response is captured LAT+1 edges later.
    assign issue   = !bus.abort_i &&
                     ((state == ST_SEED) || ((state == ST_RUN) && (cnt < NUM_PAT_C)));
    assign capture = !bus.abort_i && vpipe[VW-1];

    // Control FSM, pattern issue, response compaction and verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            lfsr   <= '0;
            pat    <= '0;
            misr   <= '0;
            golden <= '0;
            cnt    <= '0;
            vpipe  <= '0;
            pass   <= 1'b0;
        end else if (bus.abort_i) begin
            // Abort stops everything but keeps the datapath for inspection.
            state <= ST_IDLE;
            vpipe <= '0;
            pass  <= 1'b0;
        end else begin
            vpipe <= (vpipe << 1) | VW'(issue);
            if (capture) begin
                misr <= misr_next;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE) begin
                        pass <= (misr == golden);
                    end
                    if (bus.start_i) begin
                        golden <= bus.golden_i;
                        // The all-zero LFSR state would lock up, so it is replaced by 1.
                        lfsr   <= (bus.seed_i == '0) ? N_IN'(1) : bus.seed_i;
                        misr   <= '0;
                        cnt    <= '0;
                        vpipe  <= '0;
                        pass   <= 1'b0;
                        state  <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    pat   <= lfsr;
                    lfsr  <= lfsr_next;
                    cnt   <= 17'd1;
                    state <= (NUM_PAT_C == 17'd1) ? ST_DRAIN : ST_RUN;
                end
                ST_RUN: begin
                    if (cnt < NUM_PAT_C) begin
                        pat  <= lfsr;
                        lfsr <= lfsr_next;
                        cnt  <= cnt + 17'd1;
                    end
                    // The edge issuing the last pattern also leaves RUN.
                    if (cnt >= LAST_CNT) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Once the last response has been folded in, the verdict is final.
                    if (vpipe == '0) begin
                        pass  <= (misr == golden);
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pat_o     = pat;
    assign bus.sig_o     = misr;
    assign bus.cnt_o     = cnt;
    assign bus.pass_o    = pass;
    assign bus.done_o    = (state == ST_DONE);
    assign bus.busy_o    = (state == ST_SEED) || (state == ST_RUN) || (state == ST_DRAIN);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_netlist_bist_engine.sv
// Bench for netlist_bist_engine: a 4-bit/16-pattern instance for the LFSR,
// abort and reset scenarios, a 3-pattern instance for MISR arithmetic, and four
// instances with LAT=0..3 behind a modelled pipelined netlist.
module tb_netlist_bist_engine;

    localparam int W      = 32;
    localparam int SW_PAT = 20;
    localparam logic [3:0] T2_PAT [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                           4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- models ----------------
    function automatic logic [3:0] lfsr4(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [13:0] lfsr14(input logic [13:0] x);
        return {x[12:0], 1'b0} ^ (x[13] ? 14'h2B01 : 14'h0);
    endfunction

    function automatic logic [7:0] misr8(input logic [7:0] m, input logic [7:0] r);
        return {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ r;
    endfunction

    // The combinational netlist used by the latency-sweep instances.
    function automatic logic [7:0] netlist_f(input logic [13:0] p);
        return p[7:0] ^ {p[13:8], 2'b00};
    endfunction

    function automatic logic [7:0] sweep_sig(input logic [13:0] seed, input int npat);
        logic [13:0] l;
        logic [7:0]  m;
        l = (seed == 14'h0) ? 14'h1 : seed;
        m = 8'h00;
        for (int k = 0; k < npat; k++) begin
            m = misr8(m, netlist_f(l));
            l = lfsr14(l);
        end
        return m;
    endfunction

    // ---------------- DUTs ----------------
    netlist_bist_engine_if #(.N_IN(4), .N_OUT(8)) bus_a ();
    netlist_bist_engine #(.N_IN(4), .N_OUT(8), .TAPS_IN(4'h3), .TAPS_OUT(8'h1D),
                          .NUM_PAT(16), .LAT(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    netlist_bist_engine_if #(.N_IN(14), .N_OUT(8)) bus_b ();
    netlist_bist_engine #(.N_IN(14), .N_OUT(8), .TAPS_IN(14'h2B01), .TAPS_OUT(8'h1D),
                          .NUM_PAT(3), .LAT(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [3:0]  sw_start;
    logic [13:0] sw_seed   [4];
    logic [7:0]  sw_golden [4];
    logic [3:0]  sw_done;
    logic [3:0]  sw_pass;
    logic [7:0]  sw_sig    [4];
    logic [16:0] sw_cnt    [4];

    genvar gl;
    generate
        for (gl = 0; gl < 4; gl++) begin : g_sweep
            netlist_bist_engine_if #(.N_IN(14), .N_OUT(8)) bus_s ();
            logic [7:0] rsp_pipe [4];
            netlist_bist_engine #(.N_IN(14), .N_OUT(8), .TAPS_IN(14'h2B01),
                                  .TAPS_OUT(8'h1D), .NUM_PAT(SW_PAT), .LAT(gl))
                dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

            always @(posedge clk) begin
                rsp_pipe[0] <= netlist_f(bus_s.pat_o);
                for (int i = 1; i < 4; i++) rsp_pipe[i] <= rsp_pipe[i-1];
            end

            if (gl == 0) begin : g_comb
                assign bus_s.rsp_i = netlist_f(bus_s.pat_o);
            end else begin : g_piped
                assign bus_s.rsp_i = rsp_pipe[gl-1];
            end

            assign bus_s.start_i  = sw_start[gl];
            assign bus_s.abort_i  = 1'b0;
            assign bus_s.seed_i   = sw_seed[gl];
            assign bus_s.golden_i = sw_golden[gl];
            assign sw_done[gl]    = bus_s.done_o;
            assign sw_pass[gl]    = bus_s.pass_o;
            assign sw_sig[gl]     = bus_s.sig_o;
            assign sw_cnt[gl]     = bus_s.cnt_o;
        end
    endgenerate

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [W-1:0] act);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %0h expected <empty queue>", name, act);
        end else begin
            chk(name, act, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    typedef struct {
        logic [3:0] seed;
        logic [7:0] golden;
        logic       exp_pass;
        logic       lit;
    } run_vec_t;

    // Full run on dut_a with rsp tied to 0: every issued pattern, hold, latency, verdict.
    task automatic run_a(input logic [3:0] seed, input logic [7:0] golden,
                         input logic exp_pass, input logic lit);
        logic [3:0] l;
        logic [3:0] last;
        @(negedge clk);
        bus_a.seed_i   = seed;
        bus_a.golden_i = golden;
        bus_a.start_i  = 1'b1;
        l    = (seed == 4'h0) ? 4'h1 : seed;
        last = 4'h0;
        for (int k = 0; k < 16; k++) begin
            last = lit ? T2_PAT[k] : l;
            exp_q.push_back(W'(last));
            l = lfsr4(l);
        end
        @(posedge clk); #1;
        bus_a.start_i = 1'b0;
        chk("a_busy_seed", W'(bus_a.busy_o), W'(1));
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            pop_chk("a_pat", W'(bus_a.pat_o));
        end
        @(posedge clk); #1;
        chk("a_pat_hold", W'(bus_a.pat_o), W'(last));
        chk("a_not_done_early", W'(bus_a.done_o), W'(0));
        @(posedge clk); #1;
        chk("a_done", W'(bus_a.done_o), W'(1));
        chk("a_busy_done", W'(bus_a.busy_o), W'(0));
        chk("a_pass", W'(bus_a.pass_o), W'(exp_pass));
        chk("a_sig", W'(bus_a.sig_o), W'(0));
        chk("a_cnt", W'(bus_a.cnt_o), W'(16));
    endtask

    // Three-pattern run on dut_b with hand-driven responses 01, 80, 00.
    task automatic run_b(input logic [7:0] golden, input logic exp_pass);
        logic [7:0] rsp_seq [3];
        logic [7:0] m;
        rsp_seq[0] = 8'h01; rsp_seq[1] = 8'h80; rsp_seq[2] = 8'h00;
        @(negedge clk);
        bus_b.seed_i   = 14'h0ACE;
        bus_b.golden_i = golden;
        bus_b.start_i  = 1'b1;
        m = 8'h00;
        for (int k = 0; k < 3; k++) begin
            m = misr8(m, rsp_seq[k]);
            exp_q.push_back(W'(m));
        end
        exp_q.push_back(W'(exp_pass));
        @(posedge clk); #1;
        bus_b.start_i = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            bus_b.rsp_i = rsp_seq[k];
            @(posedge clk); #1;
            pop_chk("b_sig", W'(bus_b.sig_o));
        end
        bus_b.rsp_i = 8'h00;
        @(posedge clk); #1;
        chk("b_done", W'(bus_b.done_o), W'(1));
        pop_chk("b_pass", W'(bus_b.pass_o));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        run_vec_t   vecs [4];
        logic [7:0] model_sig;
        int         done_at [4];
        logic [3:0] pat_abort;

        vecs[0] = '{seed: 4'h1, golden: 8'h00, exp_pass: 1'b1, lit: 1'b1};
        vecs[1] = '{seed: 4'h0, golden: 8'h00, exp_pass: 1'b1, lit: 1'b0};
        vecs[2] = '{seed: 4'h5, golden: 8'h03, exp_pass: 1'b0, lit: 1'b0};
        vecs[3] = '{seed: 4'h8, golden: 8'h00, exp_pass: 1'b1, lit: 1'b0};

        bus_a.start_i = 1'b0; bus_a.abort_i = 1'b0; bus_a.seed_i = '0;
        bus_a.golden_i = '0;  bus_a.rsp_i = '0;
        bus_b.start_i = 1'b0; bus_b.abort_i = 1'b0; bus_b.seed_i = '0;
        bus_b.golden_i = '0;  bus_b.rsp_i = '0;
        sw_start = '0;
        for (int l = 0; l < 4; l++) begin
            sw_seed[l] = '0; sw_golden[l] = '0; done_at[l] = 0;
        end

        // Reset state.
        #23;
        chk("rst_a_busy", W'(bus_a.busy_o), W'(0));
        chk("rst_a_done", W'(bus_a.done_o), W'(0));
        chk("rst_a_pat", W'(bus_a.pat_o), W'(0));
        chk("rst_b_cnt", W'(bus_b.cnt_o), W'(0));
        chk("rst_b_sig", W'(bus_b.sig_o), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LFSR sequence and zero-seed substitution, table driven.
        for (int v = 0; v < 4; v++) begin
            run_a(vecs[v].seed, vecs[v].golden, vecs[v].exp_pass, vecs[v].lit);
        end

        // MISR arithmetic: a wrong golden, then the right one.
        run_b(8'h18, 1'b0);
        run_b(misr8(misr8(misr8(8'h00, 8'h01), 8'h80), 8'h00), 1'b1);

        // Latency sweep LAT=0..3, with a start re-pulse while busy.
        for (int l = 0; l < 4; l++) begin
            sw_seed[l] = (l == 0) ? 14'h0001 : (l == 1) ? 14'h1234 : (l == 2) ? 14'h3FFF : 14'h0000;
            model_sig = sweep_sig(sw_seed[l], SW_PAT);
            sw_golden[l] = (l == 2) ? (model_sig ^ 8'h01) : model_sig;
            exp_q.push_back(W'(SW_PAT + l + 2));
            exp_q.push_back(W'(model_sig));
            exp_q.push_back(W'((l == 2) ? 0 : 1));
            exp_q.push_back(W'(SW_PAT));
        end
        @(negedge clk);
        sw_start = 4'hF;
        @(posedge clk); #1;
        sw_start = 4'h0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 3) sw_start = 4'hF;
            if (n == 4) sw_start = 4'h0;
            for (int l = 0; l < 4; l++) begin
                if (sw_done[l] && done_at[l] == 0) done_at[l] = n;
            end
            if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0 && done_at[3] != 0) break;
        end
        for (int l = 0; l < 4; l++) begin
            pop_chk("sw_latency", W'(done_at[l]));
            pop_chk("sw_sig", W'(sw_sig[l]));
            pop_chk("sw_pass", W'(sw_pass[l]));
            pop_chk("sw_cnt", W'(sw_cnt[l]));
        end

        // Abort together with start in RUN, then a fresh run.
        @(negedge clk);
        bus_a.seed_i = 4'h1; bus_a.golden_i = 8'h00; bus_a.start_i = 1'b1;
        pat_abort = lfsr4(lfsr4(lfsr4(4'h1)));
        @(posedge clk); #1;
        bus_a.start_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
        end
        bus_a.abort_i = 1'b1; bus_a.start_i = 1'b1;
        @(posedge clk); #1;
        bus_a.abort_i = 1'b0; bus_a.start_i = 1'b0;
        chk("ab_busy", W'(bus_a.busy_o), W'(0));
        chk("ab_done", W'(bus_a.done_o), W'(0));
        chk("ab_state", W'(bus_a.dbg_state), W'(0));
        chk("ab_pat_kept", W'(bus_a.pat_o), W'(pat_abort));
        chk("ab_cnt_kept", W'(bus_a.cnt_o), W'(4));
        @(posedge clk); #1;
        chk("ab_still_idle", W'(bus_a.busy_o), W'(0));
        run_a(4'h3, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        bus_a.abort_i = 1'b1;
        @(posedge clk); #1;
        bus_a.abort_i = 1'b0;
        chk("ab_done_cleared", W'(bus_a.done_o), W'(0));
        chk("ab_pass_cleared", W'(bus_a.pass_o), W'(0));

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bus_a.seed_i = 4'h6; bus_a.start_i = 1'b1; bus_a.rsp_i = 8'h5A;
        @(posedge clk); #1;
        bus_a.start_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        chk("t1_sig_pre", W'(bus_a.sig_o != 8'h00), W'(1));
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t1_busy", W'(bus_a.busy_o), W'(0));
        chk("t1_done", W'(bus_a.done_o), W'(0));
        chk("t1_pass", W'(bus_a.pass_o), W'(0));
        chk("t1_pat", W'(bus_a.pat_o), W'(0));
        chk("t1_sig", W'(bus_a.sig_o), W'(0));
        chk("t1_cnt", W'(bus_a.cnt_o), W'(0));
        bus_a.rsp_i = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_idle_after", W'(bus_a.dbg_state), W'(0));
        chk("t1_busy_after", W'(bus_a.busy_o), W'(0));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
